// File: rtl/decode_ctrl_stage.sv
// decode_ctrl_stage: one-entry registered RV32I(+M) control decoder between fetch
// and execute, with valid/ready handshakes, flush, load-use stalling, illegal
// instruction flagging and a saturating illegal-instruction counter.
module decode_ctrl_stage #(
    parameter int ENABLE_M       = 0,
    parameter int LOAD_USE_STALL = 1,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             RegWrite,
    output logic             ALUSrc,
    output logic             ALUSrcA,
    output logic [3:0]       ALUCtrl,
    output logic [2:0]       IMMSrc,
    output logic [2:0]       MemCtrl,
    output logic [2:0]       PCSrc,
    output logic             MemWrite,
    output logic [1:0]       ResultSrc,
    output logic             MulDivEn,
    output logic [2:0]       MulDivOp,
    output logic [4:0]       rd,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_count
);
    localparam logic [3:0] ALU_OPCODE_ADD  = 4'd0;
    localparam logic [3:0] ALU_OPCODE_SUB  = 4'd1;
    localparam logic [3:0] ALU_OPCODE_SLL  = 4'd2;
    localparam logic [3:0] ALU_OPCODE_SLT  = 4'd3;
    localparam logic [3:0] ALU_OPCODE_SLTU = 4'd4;
    localparam logic [3:0] ALU_OPCODE_XOR  = 4'd5;
    localparam logic [3:0] ALU_OPCODE_LSR  = 4'd6;
    localparam logic [3:0] ALU_OPCODE_ASR  = 4'd7;
    localparam logic [3:0] ALU_OPCODE_OR   = 4'd8;
    localparam logic [3:0] ALU_OPCODE_AND  = 4'd9;
    localparam logic [3:0] ALU_OPCODE_B    = 4'd10;

    localparam logic [2:0] SIGN_EXTEND_I = 3'd0;
    localparam logic [2:0] SIGN_EXTEND_S = 3'd1;
    localparam logic [2:0] SIGN_EXTEND_B = 3'd2;
    localparam logic [2:0] SIGN_EXTEND_U = 3'd3;
    localparam logic [2:0] SIGN_EXTEND_J = 3'd4;

    localparam logic [2:0] MEM_B  = 3'd0;
    localparam logic [2:0] MEM_H  = 3'd1;
    localparam logic [2:0] MEM_W  = 3'd2;
    localparam logic [2:0] MEM_BU = 3'd3;
    localparam logic [2:0] MEM_HU = 3'd4;

    localparam logic [2:0] PC_NEXT          = 3'd0;
    localparam logic [2:0] PC_ALWAYS_BRANCH = 3'd1;
    localparam logic [2:0] PC_BEQ           = 3'd2;
    localparam logic [2:0] PC_BNE           = 3'd3;
    localparam logic [2:0] PC_BLT           = 3'd4;
    localparam logic [2:0] PC_BGE           = 3'd5;
    localparam logic [2:0] PC_BLTU          = 3'd6;
    localparam logic [2:0] PC_BGEU          = 3'd7;

    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_OPIMM  = 7'h13;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;

    localparam int HZ_W = (LOAD_USE_STALL > 1) ? $clog2(LOAD_USE_STALL + 1) : 1;

    typedef struct packed {
        logic       reg_write;
        logic       alu_src;
        logic       alu_src_a;
        logic [3:0] alu_ctrl;
        logic [2:0] imm_src;
        logic [2:0] mem_ctrl;
        logic [2:0] pc_src;
        logic       mem_write;
        logic [1:0] result_src;
        logic       muldiv_en;
        logic [2:0] muldiv_op;
        logic       illegal;
    } bundle_t;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    bundle_t         dec;
    logic            bad;
    logic            reads_rs1;
    logic            reads_rs2;
    logic            hazard;
    logic            accept;
    logic            out_valid_q;
    bundle_t         bundle_q;
    logic [4:0]      rd_q, rs1_q, rs2_q;
    logic [CNT_W-1:0] ill_cnt_q;
    logic [HZ_W-1:0] hz_cnt_q;
    logic [4:0]      ld_rd_q;

    assign opcode = instr_in[6:0];
    assign funct3 = instr_in[14:12];
    assign funct7 = instr_in[31:25];

    function automatic logic [3:0] alu_base(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_OPCODE_ADD;
            3'b001:  return ALU_OPCODE_SLL;
            3'b010:  return ALU_OPCODE_SLT;
            3'b011:  return ALU_OPCODE_SLTU;
            3'b100:  return ALU_OPCODE_XOR;
            3'b101:  return ALU_OPCODE_LSR;
            3'b110:  return ALU_OPCODE_OR;
            default: return ALU_OPCODE_AND;
        endcase
    endfunction

    // Combinational decode of instr_in into a control bundle; illegal encodings collapse to a safe no-op.
    always_comb begin
        dec = '0;
        bad = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec.reg_write = 1'b1;
                if (funct7 == 7'h01 && ENABLE_M != 0) begin
                    dec.muldiv_en = 1'b1;
                    dec.muldiv_op = funct3;
                end else if (funct7 == 7'h00) dec.alu_ctrl = alu_base(funct3);
                else if (funct7 == 7'h20 && funct3 == 3'b000) dec.alu_ctrl = ALU_OPCODE_SUB;
                else if (funct7 == 7'h20 && funct3 == 3'b101) dec.alu_ctrl = ALU_OPCODE_ASR;
                else bad = 1'b1;
            end
            OPC_OPIMM: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.imm_src   = SIGN_EXTEND_I;
                dec.alu_ctrl  = alu_base(funct3);
                if (funct3 == 3'b001 && funct7 != 7'h00 && funct7 != 7'h20) bad = 1'b1;
                if (funct3 == 3'b101) begin
                    if (funct7 == 7'h20) dec.alu_ctrl = ALU_OPCODE_ASR;
                    else if (funct7 != 7'h00) bad = 1'b1;
                end
            end
            OPC_LOAD: begin
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.imm_src    = SIGN_EXTEND_I;
                dec.result_src = 2'd1;
                case (funct3)
                    3'b000:  dec.mem_ctrl = MEM_B;
                    3'b001:  dec.mem_ctrl = MEM_H;
                    3'b010:  dec.mem_ctrl = MEM_W;
                    3'b100:  dec.mem_ctrl = MEM_BU;
                    3'b101:  dec.mem_ctrl = MEM_HU;
                    default: bad = 1'b1;
                endcase
            end
            OPC_STORE: begin
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.imm_src   = SIGN_EXTEND_S;
                case (funct3)
                    3'b000:  dec.mem_ctrl = MEM_B;
                    3'b001:  dec.mem_ctrl = MEM_H;
                    3'b010:  dec.mem_ctrl = MEM_W;
                    default: bad = 1'b1;
                endcase
            end
            OPC_BRANCH: begin
                dec.imm_src = SIGN_EXTEND_B;
                case (funct3)
                    3'b000:  begin dec.pc_src = PC_BEQ;  dec.alu_ctrl = ALU_OPCODE_SUB;  end
                    3'b001:  begin dec.pc_src = PC_BNE;  dec.alu_ctrl = ALU_OPCODE_SUB;  end
                    3'b100:  begin dec.pc_src = PC_BLT;  dec.alu_ctrl = ALU_OPCODE_SLT;  end
                    3'b101:  begin dec.pc_src = PC_BGE;  dec.alu_ctrl = ALU_OPCODE_SLT;  end
                    3'b110:  begin dec.pc_src = PC_BLTU; dec.alu_ctrl = ALU_OPCODE_SLTU; end
                    3'b111:  begin dec.pc_src = PC_BGEU; dec.alu_ctrl = ALU_OPCODE_SLTU; end
                    default: bad = 1'b1;
                endcase
            end
            OPC_JAL: begin
                dec.reg_write  = 1'b1;
                dec.alu_src_a  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.imm_src    = SIGN_EXTEND_J;
                dec.result_src = 2'd2;
                dec.pc_src     = PC_ALWAYS_BRANCH;
            end
            OPC_JALR: begin
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.imm_src    = SIGN_EXTEND_I;
                dec.result_src = 2'd2;
                dec.pc_src     = PC_ALWAYS_BRANCH;
                if (funct3 != 3'b000) bad = 1'b1;
            end
            OPC_LUI: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.imm_src   = SIGN_EXTEND_U;
                dec.alu_ctrl  = ALU_OPCODE_B;
            end
            OPC_AUIPC: begin
                dec.reg_write = 1'b1;
                dec.alu_src_a = 1'b1;
                dec.alu_src   = 1'b1;
                dec.imm_src   = SIGN_EXTEND_U;
            end
            default: bad = 1'b1;
        endcase
        if (bad) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
    end

    // Which source registers the incoming instruction actually reads, for hazard matching.
    always_comb begin
        reads_rs1 = !(opcode == OPC_LUI || opcode == OPC_AUIPC || opcode == OPC_JAL);
        reads_rs2 = (opcode == OPC_OP || opcode == OPC_STORE || opcode == OPC_BRANCH);
    end

    assign hazard = (LOAD_USE_STALL != 0) && (hz_cnt_q != '0) && in_valid && (ld_rd_q != 5'd0) &&
                    ((reads_rs1 && instr_in[19:15] == ld_rd_q) ||
                     (reads_rs2 && instr_in[24:20] == ld_rd_q));
    assign in_ready = (!out_valid_q || out_ready) && !hazard;
    // A flushed cycle never accepts, even though in_ready may read high.
    assign accept   = in_valid && in_ready && !flush;

    // Output bundle register: loads on accept, drains when consumed, holds while stalled downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            bundle_q    <= '0;
            rd_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            bundle_q    <= dec;
            rd_q        <= instr_in[11:7];
            rs1_q       <= instr_in[19:15];
            rs2_q       <= instr_in[24:20];
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // Saturating count of accepted illegal instructions; flush does not touch it.
    always_ff @(posedge clk) begin
        if (rst) ill_cnt_q <= '0;
        else if (accept && dec.illegal && ill_cnt_q != '1) ill_cnt_q <= ill_cnt_q + CNT_W'(1);
    end

    // Load-use window: armed by an accepted legal load writing a non-x0 register, then counts down.
    always_ff @(posedge clk) begin
        if (rst) begin
            hz_cnt_q <= '0;
            ld_rd_q  <= '0;
        end else if (flush) begin
            hz_cnt_q <= '0;
        end else if (accept && opcode == OPC_LOAD && !dec.illegal && instr_in[11:7] != 5'd0) begin
            hz_cnt_q <= HZ_W'(LOAD_USE_STALL);
            ld_rd_q  <= instr_in[11:7];
        end else if (hz_cnt_q != '0) begin
            hz_cnt_q <= hz_cnt_q - HZ_W'(1);
        end
    end

    assign out_valid     = out_valid_q;
    assign RegWrite      = bundle_q.reg_write;
    assign ALUSrc        = bundle_q.alu_src;
    assign ALUSrcA       = bundle_q.alu_src_a;
    assign ALUCtrl       = bundle_q.alu_ctrl;
    assign IMMSrc        = bundle_q.imm_src;
    assign MemCtrl       = bundle_q.mem_ctrl;
    assign PCSrc         = bundle_q.pc_src;
    assign MemWrite      = bundle_q.mem_write;
    assign ResultSrc     = bundle_q.result_src;
    assign MulDivEn      = bundle_q.muldiv_en;
    assign MulDivOp      = bundle_q.muldiv_op;
    assign illegal       = bundle_q.illegal;
    assign rd            = rd_q;
    assign rs1           = rs1_q;
    assign rs2           = rs2_q;
    assign illegal_count = ill_cnt_q;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Testbench for decode_ctrl_stage: directed scenarios plus a randomized run
// against a behavioural model. Instance 0: ENABLE_M=0, LOAD_USE_STALL=1;
// instance 1: ENABLE_M=1, LOAD_USE_STALL=2. Both share the same stimulus.
module tb_decode_ctrl_stage;
    localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_SLL = 4'd2, A_SLT = 4'd3, A_SLTU = 4'd4,
                           A_XOR = 4'd5, A_LSR = 4'd6, A_ASR = 4'd7, A_OR = 4'd8, A_AND = 4'd9, A_B = 4'd10;
    localparam logic [2:0] X_I = 3'd0, X_S = 3'd1, X_B = 3'd2, X_U = 3'd3, X_J = 3'd4;
    localparam logic [2:0] M_B = 3'd0, M_H = 3'd1, M_W = 3'd2, M_BU = 3'd3, M_HU = 3'd4;
    localparam logic [2:0] P_NEXT = 3'd0, P_ALWAYS = 3'd1, P_BEQ = 3'd2, P_BNE = 3'd3,
                           P_BLT = 3'd4, P_BGE = 3'd5, P_BLTU = 3'd6, P_BGEU = 3'd7;
    localparam logic [3:0] ALU_MAP [8] = '{A_ADD, A_SLL, A_SLT, A_SLTU, A_XOR, A_LSR, A_OR, A_AND};
    localparam int STALL [2] = '{1, 2};

    typedef struct packed {
        logic rw; logic asrc; logic asrca; logic [3:0] alu; logic [2:0] imm; logic [2:0] mem;
        logic [2:0] pc; logic mw; logic [1:0] res; logic mde; logic [2:0] mdo; logic ill;
        logic [4:0] rd; logic [4:0] rs1; logic [4:0] rs2;
    } bun_t;

    logic clk = 1'b0, rst, flush, in_valid, out_ready;
    logic [31:0] instr;
    logic [1:0] rdy_w, ov_w, rw_w, asrc_w, asrca_w, mw_w, mde_w, ill_w;
    logic [3:0] alu_w [2];
    logic [2:0] imm_w [2], mem_w [2], pc_w [2], mdo_w [2];
    logic [1:0] res_w [2];
    logic [4:0] rd_w [2], rs1_w [2], rs2_w [2];
    logic [7:0] icnt_w [2];
    bun_t act [2];
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        decode_ctrl_stage #(.ENABLE_M(g), .LOAD_USE_STALL(g + 1), .CNT_W(8)) u_dut (
            .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_w[g]),
            .instr_in(instr), .out_valid(ov_w[g]), .out_ready(out_ready),
            .RegWrite(rw_w[g]), .ALUSrc(asrc_w[g]), .ALUSrcA(asrca_w[g]), .ALUCtrl(alu_w[g]),
            .IMMSrc(imm_w[g]), .MemCtrl(mem_w[g]), .PCSrc(pc_w[g]), .MemWrite(mw_w[g]),
            .ResultSrc(res_w[g]), .MulDivEn(mde_w[g]), .MulDivOp(mdo_w[g]),
            .rd(rd_w[g]), .rs1(rs1_w[g]), .rs2(rs2_w[g]), .illegal(ill_w[g]),
            .illegal_count(icnt_w[g]));
        assign act[g] = {rw_w[g], asrc_w[g], asrca_w[g], alu_w[g], imm_w[g], mem_w[g], pc_w[g],
                         mw_w[g], res_w[g], mde_w[g], mdo_w[g], ill_w[g], rd_w[g], rs1_w[g], rs2_w[g]};
    end

    // Reference decode from the instruction-set rules.
    function automatic bun_t ref_dec(input logic [31:0] ins, input bit en_m);
        bun_t b;
        logic [2:0] f3;
        logic [6:0] f7;
        bit ok;
        f3 = ins[14:12]; f7 = ins[31:25]; ok = 1'b1; b = '0;
        case (ins[6:0])
            7'h33: begin
                b.rw = 1'b1;
                if (f7 == 7'h01) begin
                    if (en_m) begin b.mde = 1'b1; b.mdo = f3; end else ok = 1'b0;
                end else if (f7 == 7'h00) b.alu = ALU_MAP[f3];
                else if (f7 == 7'h20 && f3 == 3'd0) b.alu = A_SUB;
                else if (f7 == 7'h20 && f3 == 3'd5) b.alu = A_ASR;
                else ok = 1'b0;
            end
            7'h13: begin
                b.rw = 1'b1; b.asrc = 1'b1; b.imm = X_I; b.alu = ALU_MAP[f3];
                if ((f3 == 3'd1 || f3 == 3'd5) && !(f7 == 7'h00 || f7 == 7'h20)) ok = 1'b0;
                if (f3 == 3'd5 && f7 == 7'h20) b.alu = A_ASR;
            end
            7'h03: begin
                b.rw = 1'b1; b.asrc = 1'b1; b.imm = X_I; b.res = 2'd1;
                case (f3)
                    3'd0: b.mem = M_B; 3'd1: b.mem = M_H; 3'd2: b.mem = M_W;
                    3'd4: b.mem = M_BU; 3'd5: b.mem = M_HU; default: ok = 1'b0;
                endcase
            end
            7'h23: begin
                b.mw = 1'b1; b.asrc = 1'b1; b.imm = X_S;
                if (f3 > 3'd2) ok = 1'b0; else b.mem = (f3 == 3'd0) ? M_B : (f3 == 3'd1) ? M_H : M_W;
            end
            7'h63: begin
                b.imm = X_B;
                case (f3)
                    3'd0: begin b.pc = P_BEQ;  b.alu = A_SUB;  end
                    3'd1: begin b.pc = P_BNE;  b.alu = A_SUB;  end
                    3'd4: begin b.pc = P_BLT;  b.alu = A_SLT;  end
                    3'd5: begin b.pc = P_BGE;  b.alu = A_SLT;  end
                    3'd6: begin b.pc = P_BLTU; b.alu = A_SLTU; end
                    3'd7: begin b.pc = P_BGEU; b.alu = A_SLTU; end
                    default: ok = 1'b0;
                endcase
            end
            7'h6F: begin b.rw = 1'b1; b.asrca = 1'b1; b.asrc = 1'b1; b.imm = X_J; b.res = 2'd2; b.pc = P_ALWAYS; end
            7'h67: begin
                b.rw = 1'b1; b.asrc = 1'b1; b.imm = X_I; b.res = 2'd2; b.pc = P_ALWAYS;
                if (f3 != 3'd0) ok = 1'b0;
            end
            7'h37: begin b.rw = 1'b1; b.asrc = 1'b1; b.imm = X_U; b.alu = A_B; end
            7'h17: begin b.rw = 1'b1; b.asrca = 1'b1; b.asrc = 1'b1; b.imm = X_U; end
            default: ok = 1'b0;
        endcase
        if (!ok) begin b = '0; b.ill = 1'b1; end
        b.rd = ins[11:7]; b.rs1 = ins[19:15]; b.rs2 = ins[24:20];
        return b;
    endfunction

    // Does ins depend on the register loaded within the live window?
    function automatic bit ref_hazard(input int cnt, input logic [4:0] ld, input logic [31:0] ins, input bit v);
        bit r1, r2;
        r1 = !(ins[6:0] == 7'h37 || ins[6:0] == 7'h17 || ins[6:0] == 7'h6F);
        r2 = (ins[6:0] == 7'h33 || ins[6:0] == 7'h23 || ins[6:0] == 7'h63);
        return v && cnt > 0 && ld != 5'd0 && ((r1 && ins[19:15] == ld) || (r2 && ins[24:20] == ld));
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [4:0] r0, r1, r2;
        logic [2:0] f3;
        logic [6:0] f7;
        int k;
        r0 = 5'($urandom_range(0, 3)); r1 = 5'($urandom_range(0, 3)); r2 = 5'($urandom_range(0, 3));
        f3 = 3'($urandom_range(0, 7)); k = $urandom_range(0, 11);
        case (k)
            0, 1, 2: begin
                f7 = (k == 0) ? 7'h00 : (k == 1) ? 7'h20 : 7'h01;
                return {f7, r2, r1, f3, r0, 7'h33};
            end
            3: begin
                f7 = ($urandom_range(0, 2) == 0) ? 7'h20 : ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h00;
                return {f7, 5'($urandom), r1, f3, r0, 7'h13};
            end
            4:  return {12'($urandom), r1, f3, r0, 7'h03};
            5:  return {7'($urandom), r2, r1, f3, 5'($urandom), 7'h23};
            6:  return {7'($urandom), r2, r1, f3, 5'($urandom), 7'h63};
            7:  return {20'($urandom), r0, 7'h6F};
            8:  return {12'($urandom), r1, ($urandom_range(0, 3) == 0) ? f3 : 3'd0, r0, 7'h67};
            9:  return {20'($urandom), r0, 7'h37};
            10: return {20'($urandom), r0, 7'h17};
            default: return $urandom;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instr = '0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int d = 0; d < 2; d++) begin
            checks++; if (ov_w[d] !== 1'b0) begin errors++; $display("FAIL reset_valid[%0d]: got %b want 0", d, ov_w[d]); end
            checks++; if (act[d] !== bun_t'(0)) begin errors++; $display("FAIL reset_bundle[%0d]: got %h want 0", d, act[d]); end
            checks++; if (icnt_w[d] !== 8'd0) begin errors++; $display("FAIL reset_count[%0d]: got %0d want 0", d, icnt_w[d]); end
        end
        checks++; if (rdy_w[0] !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", rdy_w[0]); end
        // Load an illegal bundle, then reset with a competing accept and flush pending.
        in_valid = 1'b1; out_ready = 1'b1; instr = 32'hFFFF_FFFF; tick();
        rst = 1'b1; flush = 1'b1; instr = 32'h0020_81B3; tick();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        checks++; if (ov_w[0] !== 1'b0) begin errors++; $display("FAIL rst_prio_valid: got %b want 0", ov_w[0]); end
        checks++; if (act[0] !== bun_t'(0)) begin errors++; $display("FAIL rst_prio_bundle: got %h want 0", act[0]); end
        checks++; if (icnt_w[0] !== 8'd0) begin errors++; $display("FAIL rst_prio_count: got %0d want 0", icnt_w[0]); end
    endtask

    task automatic test_add();
        bun_t e;
        do_reset();
        e = '0; e.rw = 1'b1; e.alu = A_ADD; e.rd = 5'd3; e.rs1 = 5'd1; e.rs2 = 5'd2;
        in_valid = 1'b1; out_ready = 1'b1; instr = 32'h0020_81B3; #1;
        checks++; if (rdy_w[0] !== 1'b1) begin errors++; $display("FAIL add_ready: got %b want 1", rdy_w[0]); end
        tick(); in_valid = 1'b0;
        checks++; if (ov_w[0] !== 1'b1) begin errors++; $display("FAIL add_valid: got %b want 1", ov_w[0]); end
        checks++; if (act[0] !== e) begin errors++; $display("FAIL add_bundle: got %h want %h", act[0], e); end
        tick();
        checks++; if (ov_w[0] !== 1'b0) begin errors++; $display("FAIL add_drain: got %b want 0", ov_w[0]); end
    endtask

    task automatic test_back_to_back();
        bun_t e;
        do_reset();
        e = '0; e.rw = 1'b1; e.asrc = 1'b1; e.imm = X_I; e.res = 2'd1; e.mem = M_W; e.rd = 5'd5; e.rs1 = 5'd1;
        in_valid = 1'b1; out_ready = 1'b1; instr = 32'h0000_A283; tick();
        checks++; if (ov_w[0] !== 1'b1 || act[0] !== e) begin errors++; $display("FAIL lw_bundle: got %b/%h want 1/%h", ov_w[0], act[0], e); end
        instr = 32'h0052_8333; #1;
        checks++; if (rdy_w[0] !== 1'b0) begin errors++; $display("FAIL lu_stall: got %b want 0", rdy_w[0]); end
        tick();
        checks++; if (ov_w[0] !== 1'b0) begin errors++; $display("FAIL lu_bubble: got %b want 0", ov_w[0]); end
        checks++; if (rdy_w[0] !== 1'b1) begin errors++; $display("FAIL lu_release: got %b want 1", rdy_w[0]); end
        tick(); in_valid = 1'b0;
        e = '0; e.rw = 1'b1; e.alu = A_ADD; e.rd = 5'd6; e.rs1 = 5'd5; e.rs2 = 5'd5;
        checks++; if (ov_w[0] !== 1'b1 || act[0] !== e) begin errors++; $display("FAIL lu_add: got %b/%h want 1/%h", ov_w[0], act[0], e); end
    endtask

    task automatic test_hold();
        bun_t ea, eb;
        do_reset();
        ea = '0; ea.rw = 1'b1; ea.asrc = 1'b1; ea.imm = X_I; ea.alu = A_ADD; ea.rd = 5'd7; ea.rs2 = 5'd5;
        eb = '0; eb.rw = 1'b1; eb.alu = A_XOR; eb.rd = 5'd8; eb.rs1 = 5'd1; eb.rs2 = 5'd2;
        in_valid = 1'b1; out_ready = 1'b0; instr = 32'h0050_0393; tick();
        instr = 32'h0020_C433;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (rdy_w[0] !== 1'b0) begin errors++; $display("FAIL hold_ready[%0d]: got %b want 0", i, rdy_w[0]); end
            checks++; if (ov_w[0] !== 1'b1 || act[0] !== ea) begin errors++; $display("FAIL hold_bundle[%0d]: got %b/%h want 1/%h", i, ov_w[0], act[0], ea); end
            tick();
        end
        out_ready = 1'b1; #1;
        checks++; if (rdy_w[0] !== 1'b1) begin errors++; $display("FAIL hold_resume: got %b want 1", rdy_w[0]); end
        tick(); in_valid = 1'b0;
        checks++; if (ov_w[0] !== 1'b1 || act[0] !== eb) begin errors++; $display("FAIL hold_next: got %b/%h want 1/%h", ov_w[0], act[0], eb); end
        tick();
        checks++; if (ov_w[0] !== 1'b0) begin errors++; $display("FAIL hold_nodup: got %b want 0", ov_w[0]); end
    endtask

    task automatic test_mul();
        do_reset();
        in_valid = 1'b1; out_ready = 1'b1; instr = 32'h0220_81B3; tick(); in_valid = 1'b0;
        checks++; if ({mde_w[1], mdo_w[1], rw_w[1], ill_w[1]} !== 6'b1_000_1_0) begin
            errors++; $display("FAIL mul_en: got en=%b op=%0d rw=%b ill=%b want 1/0/1/0", mde_w[1], mdo_w[1], rw_w[1], ill_w[1]); end
        checks++; if ({ill_w[0], rw_w[0], mde_w[0]} !== 3'b100) begin
            errors++; $display("FAIL mul_dis: got ill=%b rw=%b en=%b want 1/0/0", ill_w[0], rw_w[0], mde_w[0]); end
        checks++; if (icnt_w[0] !== 8'd1 || icnt_w[1] !== 8'd0) begin
            errors++; $display("FAIL mul_count: got %0d/%0d want 1/0", icnt_w[0], icnt_w[1]); end
    endtask

    task automatic test_flush();
        do_reset();
        in_valid = 1'b1; out_ready = 1'b0; instr = 32'h0000_A283; tick();
        instr = 32'h0052_8333; flush = 1'b1; tick(); flush = 1'b0;
        for (int d = 0; d < 2; d++) begin
            checks++; if (ov_w[d] !== 1'b0) begin errors++; $display("FAIL flush_valid[%0d]: got %b want 0", d, ov_w[d]); end
            checks++; if (rdy_w[d] !== 1'b1) begin errors++; $display("FAIL flush_ready[%0d]: got %b want 1", d, rdy_w[d]); end
        end
        tick(); in_valid = 1'b0;
        for (int d = 0; d < 2; d++) begin
            checks++; if (ov_w[d] !== 1'b1 || rd_w[d] !== 5'd6) begin errors++; $display("FAIL flush_accept[%0d]: got %b rd=%0d want 1 rd=6", d, ov_w[d], rd_w[d]); end
        end
        out_ready = 1'b1; tick();
    endtask

    task automatic test_saturate();
        do_reset();
        in_valid = 1'b1; out_ready = 1'b1; instr = 32'hFFFF_FFFF;
        for (int i = 0; i < 200; i++) tick();
        checks++; if (icnt_w[0] !== 8'd200) begin errors++; $display("FAIL sat_mid: got %0d want 200", icnt_w[0]); end
        for (int i = 200; i < 260; i++) tick();
        in_valid = 1'b0; tick();
        checks++; if (icnt_w[0] !== 8'd255) begin errors++; $display("FAIL sat_end: got %0d want 255", icnt_w[0]); end
    endtask

    task automatic test_random();
        bit   mv [2];
        bun_t mb [2];
        int   hz [2], ic [2];
        logic [4:0] ldrd [2];
        bit erdy, acc;
        bun_t dv;
        do_reset();
        for (int d = 0; d < 2; d++) begin mv[d] = 0; mb[d] = '0; hz[d] = 0; ic[d] = 0; ldrd[d] = '0; end
        for (int n = 0; n < 800; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 24) == 0);
            instr     = rand_instr();
            #1;
            for (int d = 0; d < 2; d++) begin
                erdy = (!mv[d] || out_ready) && !ref_hazard(hz[d], ldrd[d], instr, in_valid);
                checks++; if (rdy_w[d] !== erdy) begin errors++; $display("FAIL rnd_ready[%0d] n=%0d: got %b want %b", d, n, rdy_w[d], erdy); end
                checks++; if (ov_w[d] !== mv[d]) begin errors++; $display("FAIL rnd_valid[%0d] n=%0d: got %b want %b", d, n, ov_w[d], mv[d]); end
                if (mv[d]) begin
                    checks++; if (act[d] !== mb[d]) begin errors++; $display("FAIL rnd_bundle[%0d] n=%0d: got %h want %h", d, n, act[d], mb[d]); end
                end
                checks++; if (icnt_w[d] !== 8'(ic[d])) begin errors++; $display("FAIL rnd_count[%0d] n=%0d: got %0d want %0d", d, n, icnt_w[d], ic[d]); end
                acc = in_valid && erdy && !flush;
                dv  = ref_dec(instr, d == 1);
                if (flush) mv[d] = 0;
                else if (acc) begin mv[d] = 1; mb[d] = dv; end
                else if (out_ready) mv[d] = 0;
                if (acc && dv.ill && ic[d] < 255) ic[d]++;
                if (flush) hz[d] = 0;
                else if (acc && instr[6:0] == 7'h03 && !dv.ill && dv.rd != 5'd0) begin hz[d] = STALL[d]; ldrd[d] = dv.rd; end
                else if (hz[d] > 0) hz[d]--;
            end
            tick();
        end
        in_valid = 1'b0; flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_hold();
        test_mul();
        test_flush();
        test_saturate();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
